vec_seq_engine: RTL and testbench

- Parametrised vector sequencer. Captures two operand vectors and an opcode through a valid/ready start handshake.
- Streams the vectors LANES elements per cycle through a per-lane ALU, writes widened results into a flat result register, then pulses done.
- Next-generation host-side vector block. Operands are snapshotted at start instead of read live, throughput is configurable, and the block adds abort and prefix-accumulate behaviour.

---
 rtl/vec_seq_pkg.sv | 28 ++
 rtl/vec_seq_lane_alu.sv | 64 ++++++
 rtl/vec_seq_engine.sv | 144 ++++++++++++++
 tb/tb_vec_seq_engine.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vec_seq_pkg.sv
// vec_seq_pkg: opcodes, FSM state type and sizing helper shared by the vec_seq_engine files.
// Rev 1.0
`default_nettype none

package vec_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_MAX  = 3'd6;
  localparam logic [2:0] OP_PSUM = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int chunk_count(input int num_elem, input int lanes);
    return num_elem / lanes;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vec_seq_lane_alu.sv
// vec_seq_lane_alu: combinational per-lane ALU; acc_in/acc_out chain lanes for the PSUM prefix.
// Saturating PSUM is selected by VEC_SEQ_SAT_EN. Rev 1.0
`default_nettype none

module vec_seq_lane_alu
  import vec_seq_pkg::*;
#(
  parameter int ELEM_W = 8,
  parameter int RES_W  = 16
) (
  input  logic [2:0]        op,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  input  logic [RES_W-1:0]  acc_in,
  output logic [RES_W-1:0]  res,
  output logic [RES_W-1:0]  acc_out,
  output logic              sat
);

  logic [RES_W-1:0] za;
  logic [RES_W-1:0] zb;
  logic [RES_W-1:0] psum_val;
  logic             psum_sat;

  assign za = RES_W'(a);
  assign zb = RES_W'(b);

`ifdef VEC_SEQ_SAT_EN
  // Wide enough for the full product plus the accumulator without loss.
  localparam int SUM_W = ((RES_W > 2 * ELEM_W) ? RES_W : 2 * ELEM_W) + 1;
  logic [SUM_W-1:0] wide_sum;

  assign wide_sum = SUM_W'(a) * SUM_W'(b) + SUM_W'(acc_in);
  assign psum_sat = |wide_sum[SUM_W-1:RES_W];
  assign psum_val = psum_sat ? {RES_W{1'b1}} : wide_sum[RES_W-1:0];
`else
  assign psum_val = acc_in + za * zb;
  assign psum_sat = 1'b0;
`endif

  always_comb begin
    res     = '0;
    acc_out = acc_in;
    sat     = 1'b0;
    case (op)
      OP_ADD:  res = za + zb;
      OP_SUB:  res = za - zb;
      OP_MUL:  res = za * zb;
      OP_AND:  res = za & zb;
      OP_OR:   res = za | zb;
      OP_XOR:  res = za ^ zb;
      OP_MAX:  res = (a > b) ? za : zb;
      OP_PSUM: begin
        res     = psum_val;
        acc_out = psum_val;
        sat     = psum_sat;
      end
      default: res = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/vec_seq_engine.sv
// vec_seq_engine: snapshots two operand vectors, streams them LANES per cycle through lane ALUs.
// Optional saturating PSUM and sticky overflow via VEC_SEQ_SAT_EN. Rev 1.0
`default_nettype none

module vec_seq_engine
  import vec_seq_pkg::*;
#(
  parameter int NUM_ELEM = 8,
  parameter int ELEM_W   = 8,
  parameter int RES_W    = 2 * ELEM_W,
  parameter int LANES    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [2:0]                 op,
  input  logic [NUM_ELEM*ELEM_W-1:0] vec_a,
  input  logic [NUM_ELEM*ELEM_W-1:0] vec_b,
  input  logic                       abort,
  output logic [NUM_ELEM*RES_W-1:0]  result,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow
);

  localparam int CHUNKS = chunk_count(NUM_ELEM, LANES);
  localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  if (NUM_ELEM % LANES != 0) begin : g_lanes_check
    $error("vec_seq_engine: NUM_ELEM must be a multiple of LANES");
  end
  if (RES_W < ELEM_W + 1) begin : g_resw_check
    $error("vec_seq_engine: RES_W must be at least ELEM_W+1");
  end

  state_t                      state;
  state_t                      state_nx;
  logic [NUM_ELEM*ELEM_W-1:0]  a_snap;
  logic [NUM_ELEM*ELEM_W-1:0]  b_snap;
  logic [2:0]                  op_snap;
  logic [IDX_W-1:0]            idx;
  logic [RES_W-1:0]            acc;
  logic                        last_chunk;
  logic                        any_sat;

  logic [ELEM_W-1:0] lane_a    [LANES];
  logic [ELEM_W-1:0] lane_b    [LANES];
  logic [RES_W-1:0]  lane_res  [LANES];
  logic [RES_W-1:0]  acc_chain [LANES+1];
  logic [LANES-1:0]  lane_sat;

  assign last_chunk  = (idx == IDX_W'(CHUNKS - 1));
  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign any_sat     = |lane_sat;
  assign acc_chain[0] = acc;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign lane_a[j] = a_snap[(int'(idx) * LANES + j) * ELEM_W +: ELEM_W];
    assign lane_b[j] = b_snap[(int'(idx) * LANES + j) * ELEM_W +: ELEM_W];

    vec_seq_lane_alu #(
      .ELEM_W (ELEM_W),
      .RES_W  (RES_W)
    ) u_alu (
      .op      (op_snap),
      .a       (lane_a[j]),
      .b       (lane_b[j]),
      .acc_in  (acc_chain[j]),
      .res     (lane_res[j]),
      .acc_out (acc_chain[j+1]),
      .sat     (lane_sat[j])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Abort outranks progression; in IDLE it is ignored so a start still lands.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_valid) state_nx = RUN;
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (last_chunk) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_snap   <= '0;
      b_snap   <= '0;
      op_snap  <= '0;
      idx      <= '0;
      acc      <= '0;
      result   <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_snap   <= vec_a;
            b_snap   <= vec_b;
            op_snap  <= op;
            idx      <= '0;
            acc      <= '0;
            overflow <= 1'b0;
          end
        end
        RUN: begin
          if (!abort) begin
            for (int j = 0; j < LANES; j++) begin
              result[(int'(idx) * LANES + j) * RES_W +: RES_W] <= lane_res[j];
            end
            acc      <= acc_chain[LANES];
            overflow <= overflow | any_sat;
            idx      <= last_chunk ? '0 : idx + 1'b1;
          end
        end
        // The completion pulse is registered out of DONE, so it appears after the DONE cycle.
        DONE:    done <= !abort;
        default: done <= 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vec_seq_engine.sv
// tb_vec_seq_engine: directed self-checking bench for vec_seq_engine (default, LANES=4, RES_W=9).
// Rev 1.0
`default_nettype none

module tb_vec_seq_engine;

  logic         clk;
  logic         rst;
  logic         start_valid;
  logic [2:0]   op;
  logic [63:0]  vec_a;
  logic [63:0]  vec_b;
  logic         abort;

  logic         start_ready, busy, done, overflow;
  logic [127:0] result;
  logic         start_ready4, busy4, done4, overflow4;
  logic [127:0] result4;
  logic         start_ready9, busy9, done9, overflow9;
  logic [71:0]  result9;

  int tests = 0;
  int fails = 0;
  int done_edge, done_cnt, done4_edge, rdy_low, cnt;

  vec_seq_engine #(.NUM_ELEM(8), .ELEM_W(8), .RES_W(16), .LANES(1)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .vec_a(vec_a), .vec_b(vec_b), .abort(abort), .result(result),
    .busy(busy), .done(done), .overflow(overflow)
  );

  vec_seq_engine #(.NUM_ELEM(8), .ELEM_W(8), .RES_W(16), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready4),
    .op(op), .vec_a(vec_a), .vec_b(vec_b), .abort(abort), .result(result4),
    .busy(busy4), .done(done4), .overflow(overflow4)
  );

  vec_seq_engine #(.NUM_ELEM(8), .ELEM_W(8), .RES_W(9), .LANES(1)) dut9 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready9),
    .op(op), .vec_a(vec_a), .vec_b(vec_b), .abort(abort), .result(result9),
    .busy(busy9), .done(done9), .overflow(overflow9)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one op, then watch 12 edges: record done timing and RUN-phase start_ready.
  task automatic run_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                        input int chg_edge, output int d_edge, output int d_cnt,
                        output int d4_edge, output int r_low);
    op = o; vec_a = a; vec_b = b; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    d_edge = -1; d_cnt = 0; d4_edge = -1; r_low = 0;
    for (int n = 1; n <= 12; n++) begin
      if (n == chg_edge) vec_a = 64'h5A5A_5A5A_5A5A_5A5A;
      @(posedge clk); #1;
      if (done) begin
        d_cnt++;
        if (d_edge < 0) d_edge = n;
      end
      if (done4 && d4_edge < 0) d4_edge = n;
      if (n <= 8 && !start_ready) r_low++;
    end
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; op = 3'd0; vec_a = '0; vec_b = '0; abort = 1'b0;
    #12;
    check("reset_result", result, 128'h0);
    check("reset_busy", 128'(busy), 128'h0);
    check("reset_done", 128'(done), 128'h0);
    check("reset_ready", 128'(start_ready), 128'h1);
    check("reset_overflow", 128'(overflow), 128'h0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // SUB with a mid-RUN change of vec_a: snapshot must hold.
    run_op(3'd1, 64'h0, {8{8'h01}}, 3, done_edge, done_cnt, done4_edge, rdy_low);
    check("sub_result", result, {8{16'hFFFF}});

    // PSUM a[i]=i+1, b[i]=2 on LANES=1 and LANES=4.
    run_op(3'd7, {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, {8{8'd2}}, 0,
           done_edge, done_cnt, done4_edge, rdy_low);
    check("psum_result", result,
          {16'd72, 16'd56, 16'd42, 16'd30, 16'd20, 16'd12, 16'd6, 16'd2});
    check("psum_l4_result", result4,
          {16'd72, 16'd56, 16'd42, 16'd30, 16'd20, 16'd12, 16'd6, 16'd2});
    check("psum_l4_done_edge", 128'(done4_edge), 128'd3);
    check("psum_done_edge", 128'(done_edge), 128'd9);

    // PSUM with 0xFF*0xFF: RES_W=9 instance wraps or saturates.
    run_op(3'd7, {8{8'hFF}}, {8{8'hFF}}, 0, done_edge, done_cnt, done4_edge, rdy_low);
`ifdef VEC_SEQ_SAT_EN
    check("psum9_result", 128'(result9), 128'({8{9'h1FF}}));
    check("psum9_overflow", 128'(overflow9), 128'h1);
`else
    check("psum9_result", 128'(result9),
          128'({9'd8, 9'd7, 9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1}));
    check("psum9_overflow", 128'(overflow9), 128'h0);
`endif

    // MAX with mixed ordering.
    run_op(3'd6, {8'd112, 8'd96, 8'd80, 8'd64, 8'd48, 8'd32, 8'd16, 8'd0}, {8{8'h35}}, 0,
           done_edge, done_cnt, done4_edge, rdy_low);
    check("max_result", result,
          {16'd112, 16'd96, 16'd80, 16'd64, 16'd53, 16'd53, 16'd53, 16'd53});

    // ADD: latency, single done pulse, start_ready low through RUN.
    run_op(3'd0, {8{8'hFF}}, {8{8'h01}}, 0, done_edge, done_cnt, done4_edge, rdy_low);
    check("add_result", result, {8{16'h0100}});
    check("add_done_edge", 128'(done_edge), 128'd9);
    check("add_done_count", 128'(done_cnt), 128'd1);
    check("add_ready_low", 128'(rdy_low), 128'd8);
    check("add_overflow", 128'(overflow), 128'h0);

    // MUL aborted on its 3rd RUN edge.
    op = 3'd2; vec_a = {8{8'd3}}; vec_b = {8{8'd5}}; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 128'(busy), 128'h0);
    check("abort_ready", 128'(start_ready), 128'h1);
    check("abort_result", result, {{6{16'h0100}}, 16'h000F, 16'h000F});
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check("abort_no_done", 128'(cnt), 128'd0);

    // start and abort together in IDLE: start wins.
    op = 3'd0; vec_a = {8{8'd1}}; vec_b = {8{8'd1}}; start_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0; abort = 1'b0;
    check("idle_abort_start_busy", 128'(busy), 128'h1);
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check("idle_abort_start_done", 128'(cnt), 128'd1);
    check("idle_abort_start_result", result, {8{16'h0002}});

    // Asynchronous reset between edges mid-RUN.
    op = 3'd2; vec_a = {8{8'd7}}; vec_b = {8{8'd9}}; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("arst_result", result, 128'h0);
    check("arst_busy", 128'(busy), 128'h0);
    check("arst_done", 128'(done), 128'h0);
    check("arst_ready", 128'(start_ready), 128'h1);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
